// File: rtl/instruction_decode_stage_pkg.sv
// rtl/instruction_decode_stage_pkg.sv - RV32I opcode, funct3 and funct7 constants for the decode stage
package instruction_decode_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // funct7 selecting the plain (unsigned/logical) or alternate (signed/sub) variant
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// rtl/instruction_decode_stage_register_file.sv - 31-word register file with two bypassed read ports
module register_file
  import instruction_decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            write_enable,
  input  logic [4:0]      write_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [4:0]      read_addr_a,
  output logic [XLEN-1:0] read_data_a,
  input  logic [4:0]      read_addr_b,
  output logic [XLEN-1:0] read_data_b
);

  logic [XLEN-1:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (write_enable && write_addr != 5'd0) begin
      regs[write_addr] <= write_data;
    end
  end

  // x0 is hardwired; a same-cycle write to the addressed register is forwarded
  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    if (read_addr_a != 5'd0)
      read_data_a = (write_enable && write_addr == read_addr_a) ? write_data : regs[read_addr_a];
    if (read_addr_b != 5'd0)
      read_data_b = (write_enable && write_addr == read_addr_b) ? write_data : regs[read_addr_b];
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - RV32I decode: operand read, immediate/illegal decode, issue register
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_instruction,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            writeback_enable,
  input  logic [4:0]      writeback_rd,
  input  logic [XLEN-1:0] writeback_value,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [6:0]      issue_opcode,
  output logic [2:0]      subfunction_3,
  output logic [6:0]      subfunction_7,
  output logic [4:0]      issue_rd,
  output logic [XLEN-1:0] input_register_value,
  output logic [XLEN-1:0] second_register_value,
  output logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] issue_pc,
  output logic            issue_illegal
);

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            s;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] imm_next;
  logic            illegal_next;
  logic [4:0]      held_rs1;
  logic [4:0]      held_rs2;
  logic            accept;

  assign ins    = fetch_instruction;
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign s      = ins[31];

  register_file u_register_file (
    .clk          (clk),
    .reset        (reset),
    .write_enable (writeback_enable),
    .write_addr   (writeback_rd),
    .write_data   (writeback_value),
    .read_addr_a  (ins[19:15]),
    .read_data_a  (rs1_value),
    .read_addr_b  (ins[24:20]),
    .read_data_b  (rs2_value)
  );

  assign fetch_ready = !reset && !flush && (!issue_valid || issue_ready);
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    imm_next     = '0;
    illegal_next = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        imm_next = {{20{s}}, ins[31:20]};
        if (f3 == F3_SLL && f7 != F7_BASE) illegal_next = 1'b1;
        if (f3 == F3_SRL_SRA && f7 != F7_BASE && f7 != F7_ALT) illegal_next = 1'b1;
      end
      OPC_LOAD, OPC_JALR: imm_next = {{20{s}}, ins[31:20]};
      OPC_STORE:          imm_next = {{20{s}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:         imm_next = {{19{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm_next = {ins[31:12], 12'b0};
      OPC_JAL:            imm_next = {{11{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0};
      OPC_OP: begin
        if (f7 != F7_BASE && f7 != F7_ALT) illegal_next = 1'b1;
        if (f7 == F7_ALT && f3 != F3_ADD_SUB && f3 != F3_SRL_SRA) illegal_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) illegal_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid           <= 1'b0;
      issue_opcode          <= '0;
      subfunction_3         <= '0;
      subfunction_7         <= '0;
      issue_rd              <= '0;
      input_register_value  <= '0;
      second_register_value <= '0;
      immediate             <= '0;
      issue_pc              <= '0;
      issue_illegal         <= 1'b0;
      held_rs1              <= '0;
      held_rs2              <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (accept) begin
      issue_valid           <= 1'b1;
      issue_opcode          <= opcode;
      subfunction_3         <= f3;
      subfunction_7         <= f7;
      issue_rd              <= ins[11:7];
      input_register_value  <= rs1_value;
      second_register_value <= rs2_value;
      immediate             <= imm_next;
      issue_pc              <= fetch_pc;
      issue_illegal         <= illegal_next;
      held_rs1              <= ins[19:15];
      held_rs2              <= ins[24:20];
    end else if (issue_valid && issue_ready) begin
      issue_valid <= 1'b0;
    end else if (issue_valid && writeback_enable && writeback_rd != 5'd0) begin
      // stalled bundle picks up late writebacks to its sources
      if (writeback_rd == held_rs1) input_register_value  <= writeback_value;
      if (writeback_rd == held_rs2) second_register_value <= writeback_value;
    end
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - directed self-checking bench for instruction_decode_stage
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, fetch_valid, fetch_ready;
  logic [31:0] fetch_instruction, fetch_pc;
  logic        writeback_enable;
  logic [4:0]  writeback_rd;
  logic [31:0] writeback_value;
  logic        issue_valid, issue_ready;
  logic [6:0]  issue_opcode, subfunction_7;
  logic [2:0]  subfunction_3;
  logic [4:0]  issue_rd;
  logic [31:0] input_register_value, second_register_value, immediate, issue_pc;
  logic        issue_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .flush                 (flush),
    .fetch_valid           (fetch_valid),
    .fetch_ready           (fetch_ready),
    .fetch_instruction     (fetch_instruction),
    .fetch_pc              (fetch_pc),
    .writeback_enable      (writeback_enable),
    .writeback_rd          (writeback_rd),
    .writeback_value       (writeback_value),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_opcode          (issue_opcode),
    .subfunction_3         (subfunction_3),
    .subfunction_7         (subfunction_7),
    .issue_rd              (issue_rd),
    .input_register_value  (input_register_value),
    .second_register_value (second_register_value),
    .immediate             (immediate),
    .issue_pc              (issue_pc),
    .issue_illegal         (issue_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] instr, input logic [31:0] pc);
    fetch_instruction = instr;
    fetch_pc          = pc;
    fetch_valid       = 1'b1;
    issue_ready       = 1'b1;
    tick();
    fetch_valid       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b1; issue_ready = 1'b1;
    fetch_instruction = 32'h00500093; fetch_pc = 32'h0;
    writeback_enable = 1'b0; writeback_rd = '0; writeback_value = '0;
    #1;
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_ready: got %b want 0", fetch_ready); end
    tick(); tick();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    n_cmp++; if ({immediate, issue_pc, issue_illegal} !== 65'd0) begin n_bad++; $display("FAIL reset_fields: imm %h pc %h ill %b want 0", immediate, issue_pc, issue_illegal); end
    reset = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_addi();
    accept(32'h00500093, 32'h100);
    n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %b want 1", issue_valid); end
    n_cmp++; if (subfunction_3 !== 3'b000 || issue_rd !== 5'd1 || issue_opcode !== 7'h13) begin n_bad++; $display("FAIL addi_fields: f3 %b rd %0d op %h want 000 1 13", subfunction_3, issue_rd, issue_opcode); end
    n_cmp++; if (immediate !== 32'd5) begin n_bad++; $display("FAIL addi_imm: got %h want 00000005", immediate); end
    n_cmp++; if (input_register_value !== 32'd0 || issue_illegal !== 1'b0) begin n_bad++; $display("FAIL addi_rs1_ill: got %h %b want 0 0", input_register_value, issue_illegal); end
    n_cmp++; if (issue_pc !== 32'h100) begin n_bad++; $display("FAIL addi_pc: got %h want 00000100", issue_pc); end
  endtask

  task automatic test_bypass();
    writeback_enable = 1'b1; writeback_rd = 5'd2; writeback_value = 32'hDEADBEEF;
    accept(32'hFFF10193, 32'h104);
    writeback_enable = 1'b0;
    n_cmp++; if (input_register_value !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_rs1: got %h want deadbeef", input_register_value); end
    n_cmp++; if (immediate !== 32'hFFFFFFFF || issue_rd !== 5'd3) begin n_bad++; $display("FAIL bypass_imm_rd: got %h %0d want ffffffff 3", immediate, issue_rd); end
    // sw x2,-8(x1): rs2 now from storage, back-to-back accept
    accept(32'hFE20AC23, 32'h108);
    n_cmp++; if (second_register_value !== 32'hDEADBEEF || input_register_value !== 32'd0) begin n_bad++; $display("FAIL store_operands: got %h %h want deadbeef 0", second_register_value, input_register_value); end
    n_cmp++; if (immediate !== 32'hFFFFFFF8 || subfunction_3 !== 3'b010 || issue_pc !== 32'h108) begin n_bad++; $display("FAIL store_imm: got %h f3 %b pc %h want fffffff8 010 108", immediate, subfunction_3, issue_pc); end
  endtask

  task automatic test_stall_refresh();
    accept(32'h00028313, 32'h200);
    issue_ready = 1'b0; fetch_valid = 1'b1; fetch_instruction = 32'h00500093; fetch_pc = 32'h300;
    #1;
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL stall_fetch_ready: got %b want 0", fetch_ready); end
    writeback_enable = 1'b1; writeback_rd = 5'd5; writeback_value = 32'h1234;
    tick();
    writeback_enable = 1'b0;
    tick();
    n_cmp++; if (input_register_value !== 32'h1234) begin n_bad++; $display("FAIL stall_refresh: got %h want 00001234", input_register_value); end
    n_cmp++; if (issue_valid !== 1'b1 || issue_rd !== 5'd6 || issue_pc !== 32'h200 || immediate !== 32'd0) begin n_bad++; $display("FAIL stall_hold: v %b rd %0d pc %h imm %h want 1 6 200 0", issue_valid, issue_rd, issue_pc, immediate); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_illegal();
    accept(32'h4000D093, 32'h0);
    n_cmp++; if (issue_illegal !== 1'b0 || subfunction_7 !== 7'h20 || immediate !== 32'h400) begin n_bad++; $display("FAIL srai_legal: ill %b f7 %h imm %h want 0 20 400", issue_illegal, subfunction_7, immediate); end
    accept(32'h2000D093, 32'h0);
    n_cmp++; if (issue_illegal !== 1'b1) begin n_bad++; $display("FAIL srx_bad_f7: got %b want 1", issue_illegal); end
    accept(32'h0000007F, 32'h0);
    n_cmp++; if (issue_illegal !== 1'b1 || immediate !== 32'd0 || issue_valid !== 1'b1) begin n_bad++; $display("FAIL bad_opcode: ill %b imm %h v %b want 1 0 1", issue_illegal, immediate, issue_valid); end
    accept(32'h40001033, 32'h0);
    n_cmp++; if (issue_illegal !== 1'b1) begin n_bad++; $display("FAIL op_alt_sll: got %b want 1", issue_illegal); end
    accept(32'h00001093, 32'h0);
    n_cmp++; if (issue_illegal !== 1'b0) begin n_bad++; $display("FAIL slli_legal: got %b want 0", issue_illegal); end
  endtask

  task automatic test_immediates();
    accept(32'hFE000EE3, 32'h0);
    n_cmp++; if (immediate !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL branch_imm: got %h want fffffffc", immediate); end
    accept(32'h123450B7, 32'h0);
    n_cmp++; if (immediate !== 32'h12345000 || issue_rd !== 5'd1) begin n_bad++; $display("FAIL lui_imm: got %h rd %0d want 12345000 1", immediate, issue_rd); end
    accept(32'hFFDFF06F, 32'h0);
    n_cmp++; if (immediate !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL jal_imm: got %h want fffffffc", immediate); end
  endtask

  task automatic test_flush();
    accept(32'h00500093, 32'h0);
    fetch_valid = 1'b1; issue_ready = 1'b0; flush = 1'b1;
    #1;
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL flush_fetch_ready: got %b want 0", fetch_ready); end
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop: got %b want 0", issue_valid); end
  endtask

  task automatic test_x0_and_consume();
    writeback_enable = 1'b1; writeback_rd = 5'd0; writeback_value = 32'hFFFFFFFF;
    accept(32'h00000433, 32'h0);
    writeback_enable = 1'b0;
    n_cmp++; if (input_register_value !== 32'd0 || second_register_value !== 32'd0 || issue_illegal !== 1'b0) begin n_bad++; $display("FAIL x0_bypass: got %h %h ill %b want 0 0 0", input_register_value, second_register_value, issue_illegal); end
    accept(32'h00000433, 32'h0);
    n_cmp++; if (input_register_value !== 32'd0) begin n_bad++; $display("FAIL x0_store: got %h want 0", input_register_value); end
    issue_ready = 1'b1;
    tick();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL consume: got %b want 0", issue_valid); end
  endtask

  task automatic test_reset_mid_stall();
    accept(32'h00010093, 32'h44);
    issue_ready = 1'b0;
    n_cmp++; if (input_register_value !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_x2: got %h want deadbeef", input_register_value); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (issue_valid !== 1'b0 || input_register_value !== 32'd0 || issue_pc !== 32'd0) begin n_bad++; $display("FAIL stall_reset: v %b rs1 %h pc %h want 0 0 0", issue_valid, input_register_value, issue_pc); end
    accept(32'h00010093, 32'h48);
    n_cmp++; if (input_register_value !== 32'd0) begin n_bad++; $display("FAIL regfile_cleared: got %h want 0", input_register_value); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_stall_refresh();
    test_illegal();
    test_immediates();
    test_flush();
    test_x0_and_consume();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Decode stage directly upstream of the immediate-type and register-type ALUs. It accepts one 32-bit RV32I instruction per handshake and reads rs1/rs2 from an internal 32×32 register file, with a same-cycle write-back bypass. It generates the sign-extended immediate and presents a registered issue bundle (subfunction_3, input_register_value, immediate, ...) to the execute stage over a valid/ready handshake.

## Interface

- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  drop the held issue bundle and refuse fetch this cycle.
- fetch_valid  in  1  upstream has an instruction.
- fetch_ready  out  1  stage accepts this cycle.
- fetch_instruction  in  32  raw instruction word.
- fetch_pc  in  32  address of the instruction.
- writeback_enable  in  1  register-file write strobe.
- writeback_rd  in  5  destination register.
- writeback_value  in  32  write data.
- issue_valid  out  1  issue bundle valid.
- issue_ready  in  1  execute stage consumes the bundle.
- issue_opcode  out  7  instruction[6:0].
- subfunction_3  out  3  instruction[14:12].
- subfunction_7  out  7  instruction[31:25].
- issue_rd  out  5  instruction[11:7].
- input_register_value  out  32  rs1 operand.
- second_register_value  out  32  rs2 operand.
- immediate  out  32  format-decoded immediate.
- issue_pc  out  32  registered fetch_pc.
- issue_illegal  out  1  the bundle is an illegal instruction.

## Operation

- Register file: x0 always reads 0; writes to x0 are ignored. Read is combinational on instruction[19:15]/[24:20].
- Bypass: when writeback_enable is high, writeback_rd equals the source register, and the source register is not 0, the read returns writeback_value.
- Accept: fetch_ready = !flush && (!issue_valid || issue_ready). On fetch_valid && fetch_ready, all issue fields load, and issue_valid becomes 1.
- Consume without a new accept: issue_valid becomes 0.
- Stall (issue_valid && !issue_ready): all issue fields hold, except operand refresh. A writeback in this state to a nonzero rd that matches the held rs1 or rs2 index updates the corresponding held operand. The held rs1/rs2 indices are kept internally.
- Immediate by opcode; s = instruction[31]:
  - I-type (0010011, 0000011, 1100111): {20×s, i[31:20]}.
  - S-type (0100011): {20×s, i[31:25], i[11:7]}.
  - B-type (1100011): {19×s, s, i[7], i[30:25], i[11:8], 0}.
  - U-type (0110111, 0010111): {i[31:12], 12'b0}.
  - J-type (1101111): {11×s, s, i[19:12], i[20], i[30:21], 0}.
  - R-type (0110011) and illegal: 0.
- issue_illegal is set when any of the following holds. The instruction is still issued; the execute stage traps on it.
  - i[1:0] ≠ 11.
  - Opcode is not in the list above.
  - OP-IMM with funct3 001 and funct7 ≠ 0000000.
  - OP-IMM with funct3 101 and funct7 not 0000000 or 0100000.
  - OP with funct7 not 0000000 or 0100000.
  - OP with funct7 0100000 and funct3 not 000 or 101.
- Flush has priority over accept. The bundle is dropped: issue_valid becomes 0 next cycle, even if issue_ready is low.

## Timing

- Latency: accept at edge N → bundle visible with issue_valid=1 after edge N. Throughput is 1/cycle with issue_ready held high.
- A writeback in the same cycle as the accept is captured via the bypass. The register-file write lands at the same edge.
- Reset (also mid-stall): issue_valid=0, every issue field and issue_illegal = 0, and x1..x31 cleared to 0, all in one edge.
- fetch_ready is 0 while reset is high. Reset overrides flush and writeback.
- A writeback and a consume in the same cycle: the write lands in the register file. Refreshing the departing bundle is not required.

## Structure

- Opcode, subfunction-3, and funct7 constants belong in define.vh alongside the existing ALU subfunction codes. This includes OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, and the signed/unsigned funct7 indicators.
- One sub-module, register_file: 31 storage words, two combinational read ports with bypass, one write port, synchronous reset clear.
- Immediate generation and illegal detection are combinational in the top level. The issue register and stall/refresh logic are also in the top level.

## Test plan

- Reset, then accept 0x00500093 (addi x1,x0,5) → next cycle: issue_valid=1, subfunction_3=000, issue_rd=1, immediate=5, input_register_value=0, issue_illegal=0.
- Write back x2=0xDEADBEEF in the same cycle as accepting 0xFFF10193 (addi x3,x2,-1) → input_register_value=0xDEADBEEF, immediate=0xFFFFFFFF.
- Hold issue_ready=0 with a bundle reading x5, then write back x5=0x1234 → input_register_value becomes 0x1234, other fields unchanged, fetch_ready=0.
- Accept 0x4000D093 (srli with funct7 0100000, i.e. srai) → legal. Accept 0x2000D093 → issue_illegal=1. Accept 0x0000007F → issue_illegal=1.
- Accept 0xFE000EE3 (beq x0,x0,-4) → immediate=0xFFFFFFFC. Accept 0x123450B7 (lui) → immediate=0x12345000.
- Assert flush with fetch_valid=1 and issue_valid=1 → fetch_ready=0, issue_valid=0 next cycle. Write back to x0 → x0 still reads 0.
